// File: rtl/mul_div_unit.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and 32/32 restoring divider.
// Results land in result_hi/result_lo on entry to DONE; done pulses for one cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} state_t;
    state_t state, state_nx;

    // acc_a is A (Booth) or R (divide), one guard bit wide; m_reg is M or |B|
    logic [WIDTH:0]   acc_a;
    logic [WIDTH-1:0] acc_q;
    logic             q_m1;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r;

    logic             last_iter, b_zero;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign last_iter = (cnt == CNT_W'(1));
    assign b_zero    = (operand_b == '0);
    assign a_abs     = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign b_abs     = operand_b[WIDTH-1] ? -operand_b : operand_b;

    // Booth step: add/sub then arithmetic shift of {A,Q,q-1}
    logic [WIDTH:0]   m_ext, booth_sum, booth_a_nx;
    logic [WIDTH-1:0] booth_q_nx;

    assign m_ext = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        booth_sum = acc_a;
        case ({acc_q[0], q_m1})
            2'b01:   booth_sum = acc_a + m_ext;
            2'b10:   booth_sum = acc_a - m_ext;
            default: booth_sum = acc_a;
        endcase
    end

    assign booth_a_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    assign booth_q_nx = {booth_sum[0], acc_q[WIDTH-1:1]};

    // Restoring step on magnitudes; shifted remainder needs one extra bit
    logic [WIDTH:0]   div_shift, div_diff, div_r_nx;
    logic             div_ge;
    logic [WIDTH-1:0] div_q_nx;

    assign div_shift = {acc_a[WIDTH-1:0], acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, m_reg});
    assign div_diff  = div_shift - {1'b0, m_reg};
    assign div_r_nx  = div_ge ? div_diff : div_shift;
    assign div_q_nx  = {acc_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = !op ? MUL : (b_zero ? DONE : DIV);
            MUL:     if (last_iter) state_nx = DONE;
            DIV:     if (last_iter) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            acc_a       <= '0;
            acc_q       <= '0;
            q_m1        <= 1'b0;
            m_reg       <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    acc_a       <= '0;
                    acc_q       <= op ? a_abs : operand_b;
                    q_m1        <= 1'b0;
                    m_reg       <= op ? b_abs : operand_a;
                    cnt         <= CNT_W'(WIDTH);
                    sign_q      <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    sign_r      <= operand_a[WIDTH-1];
                    div_by_zero <= op && b_zero;
                    if (op && b_zero) begin
                        result_hi <= operand_a;
                        result_lo <= '1;
                    end
                end
                MUL: begin
                    acc_a <= booth_a_nx;
                    acc_q <= booth_q_nx;
                    q_m1  <= acc_q[0];
                    cnt   <= cnt - 1'b1;
                    if (last_iter) begin
                        result_hi <= booth_a_nx[WIDTH-1:0];
                        result_lo <= booth_q_nx;
                    end
                end
                DIV: begin
                    acc_a <= div_r_nx;
                    acc_q <= div_q_nx;
                    cnt   <= cnt - 1'b1;
                end
                FIXUP: begin
                    result_lo <= sign_q ? -acc_q : acc_q;
                    result_hi <= sign_r ? -acc_a[WIDTH-1:0] : acc_a[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results come from a behavioural
// model of signed multiply/divide and are popped when done is seen.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_hi, result_lo;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clock(Clock), .Reset(Reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint p, q, r;
        e.dbz = 1'b0;
        if (!o) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = 33;
        end else if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            q     = longint'($signed(a)) / longint'($signed(b));
            r     = longint'($signed(a)) % longint'($signed(b));
            e.hi  = r[31:0];
            e.lo  = q[31:0];
            e.lat = 34;
        end
        return e;
    endfunction

    // Launch one op; inj>0 pulses a conflicting start sampled at edge inj.
    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inj);
        exp_t e;
        int   lat;
        e = model(o, a, b);
        sb.push_back(e);
        @(negedge Clock);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge Clock);
        #1 start = 1'b0; operand_a = $urandom; operand_b = $urandom;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clock);
            start = (inj != 0 && k == inj);
            if (start) begin op = 1'b0; operand_a = $urandom; operand_b = $urandom; end
            if (k == 1 && !e.dbz) chk({tag, " dbz cleared"}, div_by_zero, 0);
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " hi"}, result_hi, e.hi);
        chk({tag, " lo"}, result_lo, e.lo);
        chk({tag, " dbz"}, div_by_zero, e.dbz);
        @(negedge Clock);
        chk({tag, " done one cycle"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int   pulses;
        exp_t h;
        #2 Reset = 1'b0;
        @(negedge Clock);
        chk("reset state", {busy, done, div_by_zero, result_hi, result_lo}, '0);
        @(negedge Clock) Reset = 1'b1;

        run_op("mul 7*-3", 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 0);
        chk("mul 7*-3 const", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Asynchronous reset mid-multiply abandons it and clears results
        @(negedge Clock);
        start = 1'b1; op = 1'b0; operand_a = 32'd9; operand_b = 32'd9;
        @(posedge Clock); #1 start = 1'b0;
        repeat (10) @(posedge Clock);
        #2 Reset = 1'b0;
        #1 chk("reset mid-mul", {busy, done, div_by_zero, result_hi, result_lo}, '0);
        pulses = 0;
        repeat (2) @(negedge Clock) pulses += int'(done);
        Reset = 1'b1;
        repeat (30) @(negedge Clock) pulses += int'(done) + int'(busy);
        chk("no done after reset", pulses, 0);
        run_op("mul 2*3", 1'b0, 32'd2, 32'd3, 0);
        chk("mul 2*3 const", {result_hi, result_lo}, 64'h0000_0000_0000_0006);

        run_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 0);
        chk("mul min*min const", {result_hi, result_lo}, 64'h4000_0000_0000_0000);
        run_op("mul min*-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        run_op("div -17/5", 1'b1, 32'hFFFF_FFEF, 32'd5, 0);
        chk("div -17/5 const", {result_hi, result_lo}, 64'hFFFF_FFFE_FFFF_FFFD);
        run_op("div 100/0", 1'b1, 32'd100, 32'd0, 0);
        chk("div 100/0 const", {result_hi, result_lo}, 64'h0000_0064_FFFF_FFFF);
        run_op("div 17/-5", 1'b1, 32'd17, 32'hFFFF_FFFB, 0);
        run_op("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div ovf const", {result_hi, result_lo}, 64'h0000_0000_8000_0000);
        run_op("div -1/min", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 0);

        for (int i = 0; i < 4; i++) begin
            run_op("mul rnd", 1'b0, $urandom, $urandom, 0);
            run_op("div rnd", 1'b1, $urandom, $urandom_range(1, 50000), 0);
        end

        run_op("div 50/7 busy start", 1'b1, 32'd50, 32'd7, 5);
        h = model(1'b1, 32'd50, 32'd7);
        chk("div 50/7 const", {result_hi, result_lo}, 64'h0000_0001_0000_0007);
        pulses = 0;
        repeat (10) @(negedge Clock) pulses += int'(done) + int'(busy);
        chk("idle quiet", pulses, 0);
        chk("hold hi", result_hi, h.hi);
        chk("hold lo", result_lo, h.lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
